fsb_term: RTL and testbench

//  Generalised 68000 front-side-bus cycle terminator for N chip-select channels.
//  - Tracks AS cycles and holds each selected channel for a programmable minimum

---
 rtl/fsb_term_if.sv | 35 +++
 rtl/fsb_term.sv | 160 ++++++++++++++++
 tb/tb_fsb_term.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsb_term_if.sv
// fsb_term_if: 68000 front-side-bus signals between the CPU, the decoder/ready sources and the terminator.
// Latency: none. This file holds wires only.
// Backpressure: none. Cycle pacing comes from the nAS / nDTACK / nVPA / nBERR handshake itself.
//
// Ports (signals):
//   nAS, CS, RDY, WS, IACS, QoSReady  -> terminator inputs
//   BACT, nDTACK, nVPA, nBERR, ACTCH  <- terminator outputs
interface fsb_term_if #(
  parameter int NCH = 4,
  parameter int WSW = 3
);
  logic               nAS;
  logic [NCH-1:0]     CS;
  logic [NCH-1:0]     RDY;
  logic [NCH*WSW-1:0] WS;
  logic               IACS;
  logic               QoSReady;
  logic               BACT;
  logic               nDTACK;
  logic               nVPA;
  logic               nBERR;
  logic [NCH-1:0]     ACTCH;

  // CPU / decoder side
  modport master (
    output nAS, CS, RDY, WS, IACS, QoSReady,
    input  BACT, nDTACK, nVPA, nBERR, ACTCH
  );

  // terminator side
  modport slave (
    input  nAS, CS, RDY, WS, IACS, QoSReady,
    output BACT, nDTACK, nVPA, nBERR, ACTCH
  );
endinterface

// File: rtl/fsb_term.sv
// fsb_term: 68000 bus-cycle terminator for NCH chip-select channels. It ends each cycle with nDTACK, nVPA or nBERR.
// Latency: the strobe falls at the earliest at posedge k+1+WS, where k is the posedge that first sees nAS low.
//          nBERR falls at posedge k+TO_CYC.
// Backpressure: the terminator holds in WAIT while RDY or QoSReady is low. Strobes stay low until nAS rises.
//
// Ports:
//   FCLK   bus clock. State changes on posedge; nAS is resampled on negedge for BACT.
//   nRESET async active-low reset.
//   bus    fsb_term_if.slave: nAS, CS, RDY, WS, IACS, QoSReady in; BACT, nDTACK, nVPA, nBERR, ACTCH out.
module fsb_term #(
  parameter int NCH    = 4,
  parameter int WSW    = 3,
  parameter int TOW    = 8,
  parameter int TO_CYC = 200
) (
  input  logic        FCLK,
  input  logic        nRESET,
  fsb_term_if.slave   bus
);

  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   actch_q, actch_d;
  logic             iack_q,  iack_d;
  logic [WSW-1:0]   wcnt_q,  wcnt_d;
  logic [TOW-1:0]   tcnt_q,  tcnt_d;
  // Internal strobe requests, active high.
  // The pins also depend on nAS, so that the pins release as soon as AS rises.
  logic             dtack_q, dtack_d;
  logic             vpa_q,   vpa_d;
  logic             berr_q,  berr_d;
  logic             asrf_q;

  logic [NCH-1:0]   sel_oh;
  logic [WSW-1:0]   sel_ws;
  logic             ok;

  // AS resampled on the falling edge. It only stretches BACT.
  always_ff @(negedge FCLK or negedge nRESET) begin
    if (!nRESET) asrf_q <= 1'b0;
    else         asrf_q <= !bus.nAS;
  end

  // Lowest-index chip select wins.
  // The loop walks downward, so the last match it writes is the lowest index.
  always_comb begin
    sel_oh = '0;
    sel_ws = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.CS[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_ws    = bus.WS[i*WSW +: WSW];
      end
    end
  end

  assign ok = (wcnt_q == '0) && bus.QoSReady && (iack_q || |(actch_q & bus.RDY));

  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      actch_q <= '0;
      iack_q  <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      dtack_q <= 1'b0;
      vpa_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      actch_q <= actch_d;
      iack_q  <= iack_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      dtack_q <= dtack_d;
      vpa_q   <= vpa_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    actch_d = actch_q;
    iack_d  = iack_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    dtack_d = dtack_q;
    vpa_d   = vpa_q;
    berr_d  = berr_q;

    case (state_q)
      IDLE: begin
        if (!bus.nAS) begin
          iack_d  = bus.IACS;
          tcnt_d  = '0;
          state_d = WAIT;
          // Interrupt-acknowledge cycles bypass the channel path entirely.
          // Such a cycle latches no channel and takes no wait states.
          if (bus.IACS) begin
            actch_d = '0;
            wcnt_d  = '0;
          end else begin
            actch_d = sel_oh;
            wcnt_d  = sel_ws;
          end
        end
      end

      WAIT: begin
        if (bus.nAS) begin
          // The CPU withdrew the cycle, so no strobe is driven.
          state_d = IDLE;
          actch_d = '0;
        end else begin
          if (wcnt_q != '0)    wcnt_d = wcnt_q - 1'b1;
          if (tcnt_q < TO_LAST) tcnt_d = tcnt_q + 1'b1;
          // On the edge where the timeout expires, a ready channel still wins.
          if (ok) begin
            state_d = ACK;
            if (iack_q) vpa_d   = 1'b1;
            else        dtack_d = 1'b1;
          end else if (tcnt_q == TO_LAST) begin
            state_d = ERR;
            berr_d  = 1'b1;
          end
        end
      end

      ACK, ERR: begin
        if (bus.nAS) begin
          state_d = IDLE;
          actch_d = '0;
          dtack_d = 1'b0;
          vpa_d   = 1'b0;
          berr_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The strobes are gated by nAS, so that they deassert as soon as AS rises.
  // They do not wait for the next clock edge.
  assign bus.nDTACK = !(dtack_q && !bus.nAS);
  assign bus.nVPA   = !(vpa_q   && !bus.nAS);
  assign bus.nBERR  = !(berr_q  && !bus.nAS);
  assign bus.BACT   = !bus.nAS || asrf_q;
  assign bus.ACTCH  = actch_q;

endmodule

// File: tb/tb_fsb_term.sv
// tb_fsb_term: directed bench for fsb_term.
// Latency: each cycle is checked at the exact posedge where a strobe must fall.
// Backpressure: QoSReady and RDY are held low to stall termination.
module tb_fsb_term;
  localparam int NCH = 4;
  localparam int WSW = 3;
  localparam int TOW = 8;
  localparam int TO_CYC = 200;

  logic FCLK;
  logic nRESET;
  int   n_cmp;
  int   n_bad;

  fsb_term_if #(.NCH(NCH), .WSW(WSW)) bus ();

  fsb_term #(.NCH(NCH), .WSW(WSW), .TOW(TOW), .TO_CYC(TO_CYC)) dut (
    .FCLK   (FCLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after the next rising edge.
  // Inputs are driven there, and registered outputs are sampled there.
  task automatic tick;
    @(posedge FCLK);
    #1;
  endtask

  // End a cycle by raising AS. Two clock edges then bring the FSM back to IDLE.
  task automatic end_cycle;
    bus.nAS = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    bus.nAS = 1'b1; bus.CS = '0; bus.RDY = '0; bus.WS = '0;
    bus.IACS = 1'b0; bus.QoSReady = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b111) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 111", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    n_cmp++;
    if (bus.ACTCH !== 4'b0000) begin
      n_bad++; $display("FAIL reset_actch: got %b want 0000", bus.ACTCH);
    end
    n_cmp++;
    if (bus.BACT !== 1'b0) begin
      n_bad++; $display("FAIL reset_bact: got %b want 0", bus.BACT);
    end
    nRESET = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait;
    bus.CS = 4'b0001; bus.RDY = 4'b0001; bus.WS = '0; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    tick(); // edge k
    n_cmp++;
    if (bus.ACTCH !== 4'b0001) begin
      n_bad++; $display("FAIL zw_actch: got %b want 0001", bus.ACTCH);
    end
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b111) begin
      n_bad++; $display("FAIL zw_k: got %b want 111", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    tick(); // edge k+1
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b011) begin
      n_bad++; $display("FAIL zw_k1: got %b want 011", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    tick(); // nDTACK holds while nAS is low
    n_cmp++;
    if (bus.nDTACK !== 1'b0) begin
      n_bad++; $display("FAIL zw_hold: got %b want 0", bus.nDTACK);
    end
    bus.nAS = 1'b1;
    #1;
    n_cmp++;
    if (bus.nDTACK !== 1'b1) begin
      n_bad++; $display("FAIL zw_async_release: got %b want 1", bus.nDTACK);
    end
    n_cmp++;
    if (bus.BACT !== 1'b1) begin
      n_bad++; $display("FAIL zw_bact_stretch: got %b want 1", bus.BACT);
    end
    @(negedge FCLK); #1;
    n_cmp++;
    if (bus.BACT !== 1'b0) begin
      n_bad++; $display("FAIL zw_bact_drop: got %b want 0", bus.BACT);
    end
    tick();
    n_cmp++;
    if (bus.ACTCH !== 4'b0000) begin
      n_bad++; $display("FAIL zw_actch_clear: got %b want 0000", bus.ACTCH);
    end
    tick();
  endtask

  task automatic test_wait_states;
    logic exp;
    // Channel 2 has WS=3. The strobe must fall exactly at k+4.
    bus.CS = 4'b0100; bus.RDY = 4'b0100; bus.WS = 12'b000_011_000_000; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      tick();
      if (j == 0) begin
        bus.CS = 4'b0001; // a CS change after the latch edge must be ignored
        bus.WS = '0;
      end
      exp = (j == 4) ? 1'b0 : 1'b1;
      n_cmp++;
      if (bus.nDTACK !== exp) begin
        n_bad++; $display("FAIL ws3_k%0d: got %b want %b", j, bus.nDTACK, exp);
      end
    end
    n_cmp++;
    if (bus.ACTCH !== 4'b0100) begin
      n_bad++; $display("FAIL ws3_actch: got %b want 0100", bus.ACTCH);
    end
    end_cycle();

    // QoSReady is held low for edges k+3..k+6, so the strobe moves to k+7.
    bus.CS = 4'b0100; bus.WS = 12'b000_011_000_000;
    bus.nAS = 1'b0;
    for (int j = 0; j <= 7; j++) begin
      tick();
      exp = (j == 7) ? 1'b0 : 1'b1;
      n_cmp++;
      if (bus.nDTACK !== exp) begin
        n_bad++; $display("FAIL qos_k%0d: got %b want %b", j, bus.nDTACK, exp);
      end
      if (j == 2) bus.QoSReady = 1'b0;
      if (j == 6) bus.QoSReady = 1'b1;
    end
    end_cycle();
  endtask

  task automatic test_iack;
    bus.IACS = 1'b1; bus.CS = '0; bus.RDY = '0; bus.WS = '1; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    tick(); // k
    tick(); // k+1
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b101) begin
      n_bad++; $display("FAIL iack_k1: got %b want 101", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    n_cmp++;
    if (bus.ACTCH !== 4'b0000) begin
      n_bad++; $display("FAIL iack_actch: got %b want 0000", bus.ACTCH);
    end
    bus.nAS = 1'b1;
    #1;
    n_cmp++;
    if (bus.nVPA !== 1'b1) begin
      n_bad++; $display("FAIL iack_async_release: got %b want 1", bus.nVPA);
    end
    tick(); tick();
    bus.IACS = 1'b0; bus.WS = '0;
  endtask

  task automatic test_timeout;
    int early;
    // The cycle is unmapped, so it can only end in a bus error at k+TO_CYC.
    bus.CS = '0; bus.RDY = 4'b1111; bus.WS = '0; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    tick(); // k
    early = 0;
    for (int j = 1; j < TO_CYC; j++) begin
      tick();
      if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b111) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++; $display("FAIL to_early: got %0d early strobe edges want 0", early);
    end
    tick(); // k+TO_CYC
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b110) begin
      n_bad++; $display("FAIL to_berr: got %b want 110", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    n_cmp++;
    if (bus.ACTCH !== 4'b0000) begin
      n_bad++; $display("FAIL to_actch: got %b want 0000", bus.ACTCH);
    end
    bus.nAS = 1'b1;
    #1;
    n_cmp++;
    if (bus.nBERR !== 1'b1) begin
      n_bad++; $display("FAIL to_async_release: got %b want 1", bus.nBERR);
    end
    tick(); tick();

    // RDY rises on the timeout edge itself, and the ACK path must win.
    bus.CS = 4'b0001; bus.RDY = 4'b0000;
    bus.nAS = 1'b0;
    tick(); // k
    early = 0;
    for (int j = 1; j < TO_CYC; j++) begin
      tick();
      if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b111) early++;
    end
    bus.RDY = 4'b0001;
    n_cmp++;
    if (early != 0) begin
      n_bad++; $display("FAIL race_early: got %0d early strobe edges want 0", early);
    end
    tick(); // k+TO_CYC
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b011) begin
      n_bad++; $display("FAIL race_ack_wins: got %b want 011", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    end_cycle();
  endtask

  task automatic test_priority_reset;
    bus.CS = 4'b0011; bus.RDY = 4'b0000; bus.WS = 12'b000_000_000_101; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    tick(); // k
    n_cmp++;
    if (bus.ACTCH !== 4'b0001) begin
      n_bad++; $display("FAIL prio_actch: got %b want 0001", bus.ACTCH);
    end
    tick(); tick();
    nRESET = 1'b0;
    #1;
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR, bus.ACTCH} !== 7'b111_0000) begin
      n_bad++; $display("FAIL midreset: got %b want 1110000", {bus.nDTACK, bus.nVPA, bus.nBERR, bus.ACTCH});
    end
    bus.nAS = 1'b1;
    #1;
    nRESET = 1'b1;
    tick(); tick();
    // A new cycle after the reset must work normally.
    bus.WS = '0; bus.RDY = 4'b0011;
    bus.nAS = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR, bus.ACTCH} !== 7'b011_0001) begin
      n_bad++; $display("FAIL post_reset: got %b want 0110001", {bus.nDTACK, bus.nVPA, bus.nBERR, bus.ACTCH});
    end
    end_cycle();
  endtask

  task automatic test_abort;
    int seen;
    bus.CS = 4'b0001; bus.RDY = 4'b0001; bus.WS = 12'b000_000_000_101; bus.QoSReady = 1'b1;
    bus.nAS = 1'b0;
    tick(); // k
    tick(); // k+1
    bus.nAS = 1'b1; // first seen high at k+2
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b111) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abort_no_strobe: got %0d strobe edges want 0", seen);
    end
    bus.WS = '0;
    bus.nAS = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.nDTACK, bus.nVPA, bus.nBERR} !== 3'b011) begin
      n_bad++; $display("FAIL abort_next: got %b want 011", {bus.nDTACK, bus.nVPA, bus.nBERR});
    end
    end_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_iack();
    test_timeout();
    test_priority_reset();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
